// File: rtl/inter_ref_pfifo_pkg.sv
// rtl/inter_ref_pfifo_pkg.sv - shared widths and Gray code helpers for inter_ref_pfifo
package inter_ref_pfifo_pkg;

    localparam int DATA_BITS = 72;
    localparam int ADDR_BITS = 7;

    // Helpers work on a 32-bit container; narrower pointers are zero-extended.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - carries a binary pointer from wrclk to rdclk through a Gray register
// and a two-flop synchronizer.
module sync_ram
    import inter_ref_pfifo_pkg::*;
#(
    parameter int addr_bits = ADDR_BITS
) (
    input  logic                 aclr,
    input  logic                 wrclk,
    input  logic                 rdclk,
    input  logic [addr_bits-1:0] data,
    output logic [addr_bits-1:0] q
);

    logic [31:0]          gray_next;
    logic [31:0]          bin_full;
    logic [addr_bits-1:0] gray_src;
    logic [addr_bits-1:0] gray_meta;
    logic [addr_bits-1:0] gray_sync;
    logic                 unused_hi;

    assign gray_next = bin2gray(32'(data));

    always_ff @(posedge wrclk or posedge aclr) begin
        if (aclr) begin
            gray_src <= '0;
        end else begin
            gray_src <= gray_next[addr_bits-1:0];
        end
    end

    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            gray_meta <= '0;
            gray_sync <= '0;
        end else begin
            gray_meta <= gray_src;
            gray_sync <= gray_meta;
        end
    end

    assign bin_full  = gray2bin(32'(gray_sync));
    assign q         = bin_full[addr_bits-1:0];
    assign unused_hi = ^{gray_next[31:addr_bits], bin_full[31:addr_bits]};

endmodule

// File: rtl/inter_ref_pfifo.sv
// rtl/inter_ref_pfifo.sv - dual-clock FIFO, registered read, no wrap bit.
// Define INTER_REF_FIFO_CHECK_EN for simulation monitors on overflow/underflow.
module inter_ref_pfifo
    import inter_ref_pfifo_pkg::*;
#(
    parameter int data_bits = DATA_BITS,
    parameter int addr_bits = ADDR_BITS
) (
    input  logic                 aclr,
    input  logic                 wr_clk,
    input  logic                 rd_clk,
    input  logic                 wr,
    input  logic [data_bits-1:0] wr_data,
    output logic                 wr_full,
    output logic [addr_bits-1:0] wr_words_avail,
    input  logic                 rd,
    output logic [data_bits-1:0] rd_data,
    output logic [addr_bits-1:0] rd_words_avail,
    output logic                 rd_empty
);

    localparam int DEPTH = 2 ** addr_bits;
    localparam logic [addr_bits-1:0] FULL_THRESH = addr_bits'(DEPTH - 3);

    logic [data_bits-1:0] mem [0:DEPTH-1];
    logic [addr_bits-1:0] wr_addr, wr_addr_next, wr_addr_synced;
    logic [addr_bits-1:0] rd_addr, rd_addr_next, rd_addr_synced;

    assign wr_addr_next = wr_addr + addr_bits'(wr);
    assign rd_addr_next = rd_addr + addr_bits'(rd);

    always_ff @(posedge wr_clk) begin
        if (wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk or posedge aclr) begin
        if (aclr) begin
            wr_addr <= '0;
        end else begin
            wr_addr <= wr_addr_next;
        end
    end

    always_ff @(posedge rd_clk or posedge aclr) begin
        if (aclr) begin
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            rd_addr <= rd_addr_next;
            if (rd) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    // Next-value crossing lets the Gray register track the pointer without an extra cycle.
    sync_ram #(.addr_bits(addr_bits)) u_wr_ptr_sync (
        .aclr  (aclr),
        .wrclk (wr_clk),
        .rdclk (rd_clk),
        .data  (wr_addr_next),
        .q     (wr_addr_synced)
    );

    sync_ram #(.addr_bits(addr_bits)) u_rd_ptr_sync (
        .aclr  (aclr),
        .wrclk (rd_clk),
        .rdclk (wr_clk),
        .data  (rd_addr_next),
        .q     (rd_addr_synced)
    );

    assign wr_words_avail = wr_addr - rd_addr_synced;
    assign rd_words_avail = wr_addr_synced - rd_addr;
    assign wr_full        = wr_words_avail > FULL_THRESH;
    assign rd_empty       = wr_addr_synced == rd_addr;

`ifdef INTER_REF_FIFO_CHECK_EN
    always @(posedge wr_clk) begin
        if (!aclr && wr && (wr_addr == rd_addr_synced - addr_bits'(1)))
            $display("%0t %m WARNING: write while full", $time);
    end

    always @(posedge rd_clk) begin
        if (!aclr && rd && rd_empty)
            $display("%0t %m WARNING: read while empty", $time);
    end
`else
`endif

endmodule

// File: tb/tb_inter_ref_pfifo.sv
// tb/tb_inter_ref_pfifo.sv - self-checking bench for inter_ref_pfifo
`timescale 1ns/1ps
module tb_inter_ref_pfifo;

    localparam int DW = 72;
    localparam int AW = 7;

    logic          aclr = 1'b1;
    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic [AW-1:0] wr_words_avail;
    logic          rd = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_words_avail;
    logic          rd_empty;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_q[$];

    inter_ref_pfifo dut (
        .aclr           (aclr),
        .wr_clk         (wr_clk),
        .rd_clk         (rd_clk),
        .wr             (wr),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .wr_words_avail (wr_words_avail),
        .rd             (rd),
        .rd_data        (rd_data),
        .rd_words_avail (rd_words_avail),
        .rd_empty       (rd_empty)
    );

    always #5    wr_clk = ~wr_clk;
    always #13.5 rd_clk = ~rd_clk;

    typedef struct {
        bit            is_wr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_rd_data;
        int            exp_avail;
        bit            exp_empty;
    } step_t;

    step_t steps[6];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        @(negedge wr_clk);
        wr = 1'b1;
        wr_data = d;
        model_q.push_back(d);
        @(negedge wr_clk);
        wr = 1'b0;
    endtask

    task automatic do_read();
        @(negedge rd_clk);
        rd = 1'b1;
        @(negedge rd_clk);
        rd = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge rd_clk);
        repeat (4) @(negedge wr_clk);
    endtask

    task automatic pulse_reset();
        #2;
        aclr = 1'b1;
        model_q.delete();
        #1;
        chk("rst_empty", DW'(rd_empty), DW'(1));
        chk("rst_full", DW'(wr_full), DW'(0));
        chk("rst_wr_avail", DW'(wr_words_avail), DW'(0));
        chk("rst_rd_avail", DW'(rd_words_avail), DW'(0));
        chk("rst_rd_data", rd_data, DW'(0));
        repeat (3) @(negedge wr_clk);
        aclr = 1'b0;
        repeat (2) @(negedge wr_clk);
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        int got;
        int cyc;
        bit pend;

        steps[0] = '{1'b1, DW'(1), DW'(0), 1, 1'b0};
        steps[1] = '{1'b1, DW'(2), DW'(0), 2, 1'b0};
        steps[2] = '{1'b1, DW'(3), DW'(0), 3, 1'b0};
        steps[3] = '{1'b0, DW'(0), DW'(1), 2, 1'b0};
        steps[4] = '{1'b0, DW'(0), DW'(2), 1, 1'b0};
        steps[5] = '{1'b0, DW'(0), DW'(3), 0, 1'b1};

        // Power-on reset, then idle
        pulse_reset();
        settle();
        chk("idle_empty", DW'(rd_empty), DW'(1));
        chk("idle_full", DW'(wr_full), DW'(0));
        chk("idle_counts", DW'({wr_words_avail, rd_words_avail}), DW'(0));

        // Small write/read sequence from the table
        for (int i = 0; i < 6; i++) begin
            if (steps[i].is_wr) begin
                do_write(steps[i].data);
            end else begin
                do_read();
                void'(model_q.pop_front());
            end
            chk($sformatf("seq%0d_rd_data", i), rd_data, steps[i].exp_rd_data);
            settle();
            chk($sformatf("seq%0d_rd_avail", i), DW'(rd_words_avail), DW'(steps[i].exp_avail));
            chk($sformatf("seq%0d_wr_avail", i), DW'(wr_words_avail), DW'(steps[i].exp_avail));
            chk($sformatf("seq%0d_empty", i), DW'(rd_empty), DW'(steps[i].exp_empty));
        end

        // Almost-full threshold: 125 words below, 126 at
        pulse_reset();
        for (int i = 0; i < 125; i++) do_write(DW'($urandom));
        settle();
        chk("full_125_avail", DW'(wr_words_avail), DW'(model_q.size()));
        chk("full_125_flag", DW'(wr_full), DW'(0));
        do_write(DW'($urandom));
        settle();
        chk("full_126_avail", DW'(wr_words_avail), DW'(model_q.size()));
        chk("full_126_flag", DW'(wr_full), DW'(1));
        chk("full_126_rd_avail", DW'(rd_words_avail), DW'(126));

        // Streaming with random gating on both sides
        pulse_reset();
        got = 0;
        fork
            begin
                int sent = 0;
                int wcyc = 0;
                while (sent < 1000 && wcyc < 30000) begin
                    @(negedge wr_clk);
                    wcyc++;
                    if (!wr_full && $urandom_range(0, 3) != 0) begin
                        wr = 1'b1;
                        wr_data = {8'($urandom), $urandom, $urandom};
                        model_q.push_back(wr_data);
                        sent++;
                    end else begin
                        wr = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr = 1'b0;
            end
            begin
                pend = 1'b0;
                cyc = 0;
                while (got < 1000 && cyc < 20000) begin
                    @(negedge rd_clk);
                    cyc++;
                    if (pend) begin
                        exp_d = model_q.pop_front();
                        chk($sformatf("stream_word%0d", got), rd_data, exp_d);
                        got++;
                    end
                    if (got >= 1000) break;
                    pend = !rd_empty && ($urandom_range(0, 3) != 0);
                    rd = pend;
                end
                rd = 1'b0;
            end
        join
        chk("stream_count", DW'(got), DW'(1000));
        settle();
        chk("stream_end_empty", DW'(rd_empty), DW'(1));
        chk("stream_end_counts", DW'({wr_words_avail, rd_words_avail}), DW'(0));

        // Reset with data stored, then a fresh word goes through
        pulse_reset();
        for (int i = 0; i < 50; i++) do_write(DW'(i + 100));
        settle();
        chk("pre_clr_avail", DW'(rd_words_avail), DW'(50));
        pulse_reset();
        do_write(DW'(8'hAB));
        settle();
        chk("post_clr_avail", DW'(rd_words_avail), DW'(1));
        do_read();
        chk("post_clr_data", rd_data, DW'(8'hAB));

        // Read on empty is unprotected: read pointer slips past write pointer
        settle();
        do_read();
        settle();
        chk("underflow_rd_avail", DW'(rd_words_avail), DW'(127));
        chk("underflow_wr_avail", DW'(wr_words_avail), DW'(127));
        chk("underflow_full", DW'(wr_full), DW'(1));
        chk("underflow_empty", DW'(rd_empty), DW'(0));
        pulse_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
